// File: rtl/node_port_arbiter.sv
// node_port_arbiter
// Shares one ring-node routing controller between three traffic sources
// (right ring, left ring, local injection). A round-robin winner is accepted
// in IDLE, the instruction and its port code are latched, controller_enable
// strobes for one cycle (ISSUE), and the instruction is held (HOLD) until
// link_ready or until HOLD_TIMEOUT cycles expire.
//
// Optional build macro: RING_PRIORITY_EN
//   defined   -> ring sources (bit0/bit1) alternate between themselves; the
//                local source is served only when no ring source is requesting.
//   undefined -> plain 3-way round-robin over all sources.
module node_port_arbiter #(
  parameter int HOLD_TIMEOUT     = 15,
  parameter int NODE_IP_BITWIDTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  in_valid,
  input  logic [31:0] in_instr0,
  input  logic [31:0] in_instr1,
  input  logic [31:0] in_instr2,
  output logic [2:0]  in_ready,
  input  logic        link_ready,
  output logic [31:0] instruction_out,
  output logic [1:0]  source_port,
  output logic        controller_enable,
  output logic        busy,
  output logic        timeout_err
);

  // The node-ID field travels inside the instruction untouched; it only has
  // to fit within the 32-bit word.
  if (NODE_IP_BITWIDTH < 1 || NODE_IP_BITWIDTH > 32) begin : g_bad_node_width
    $error("node_port_arbiter: NODE_IP_BITWIDTH must be within 1..32");
  end

  localparam bit TIMEOUT_ON  = (HOLD_TIMEOUT > 0);
  localparam int CNT_W       = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam int TO_LAST_INT = (HOLD_TIMEOUT > 0) ? (HOLD_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       rr_last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [31:0]      instr_q;
  logic [1:0]       port_q;
  logic             enable_q;
  logic             busy_q;
  logic             timeout_q;

  logic [2:0]       grant_s;
  logic [1:0]       grant_idx_s;
  logic [31:0]      grant_instr_s;

  // Round-robin pick: the search begins one past the last winner and wraps.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] valid);
    logic [2:0] g;
    g = 3'b000;
`ifdef RING_PRIORITY_EN
    if (valid[1:0] != 2'b00) begin
      if (last == 2'd0) begin
        g = valid[1] ? 3'b010 : 3'b001;
      end else begin
        g = valid[0] ? 3'b001 : 3'b010;
      end
    end else begin
      g = valid[2] ? 3'b100 : 3'b000;
    end
`else
    case (last)
      2'd0: begin
        if (valid[1])      g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else               g = 3'b000;
      end
      2'd1: begin
        if (valid[2])      g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else               g = 3'b000;
      end
      default: begin
        if (valid[0])      g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else               g = 3'b000;
      end
    endcase
`endif
    return g;
  endfunction

  // One-hot grant to 2-bit source port code.
  function automatic logic [1:0] grant_to_port(input logic [2:0] g);
    logic [1:0] p;
    case (g)
      3'b001:  p = 2'b00;
      3'b010:  p = 2'b01;
      3'b100:  p = 2'b10;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  // Grant is only offered while idle; busy states never accept a request.
  always_comb begin
    grant_s = 3'b000;
    if (state_q == IDLE) begin
      grant_s = rr_pick(rr_last_q, in_valid);
    end else begin
      grant_s = 3'b000;
    end
  end

  // Winner's port code and instruction word.
  always_comb begin
    grant_idx_s   = grant_to_port(grant_s);
    grant_instr_s = 32'h0000_0000;
    case (grant_idx_s)
      2'b00:   grant_instr_s = in_instr0;
      2'b01:   grant_instr_s = in_instr1;
      default: grant_instr_s = in_instr2;
    endcase
  end

  // Saturating increment of the HOLD wait counter.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Arbiter FSM with registered strobe, status and payload outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_last_q  <= 2'b10;
      hold_cnt_q <= '0;
      instr_q    <= 32'h0000_0000;
      port_q     <= 2'b00;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_s != 3'b000) begin
            instr_q  <= grant_instr_s;
            port_q   <= grant_idx_s;
`ifdef RING_PRIORITY_EN
            // Local grants leave the ring alternation untouched.
            if (grant_s[2] == 1'b0) begin
              rr_last_q <= grant_idx_s;
            end else begin
              rr_last_q <= rr_last_q;
            end
`else
            rr_last_q <= grant_idx_s;
`endif
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          hold_cnt_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (link_ready) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (TIMEOUT_ON && (hold_cnt_q == TO_LAST)) begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= 1'b1;
            state_q    <= HOLD;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready          = grant_s;
  assign instruction_out   = instr_q;
  assign source_port       = port_q;
  assign controller_enable = enable_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_node_port_arbiter.sv
// Directed bench for node_port_arbiter. Expected grants come from a small
// round-robin model; each accepted request pushes its expected port/payload
// to a scoreboard that is popped when controller_enable fires.
module tb_node_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid;
  logic [31:0] in_instr0, in_instr1, in_instr2;
  logic [2:0]  in_ready;
  logic        link_ready;
  logic [31:0] instruction_out;
  logic [1:0]  source_port;
  logic        controller_enable;
  logic        busy;
  logic        timeout_err;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          total = 0;
  int          bad   = 0;
  int          m_rr  = 2;
  int          seq   = 0;

  always #5 clk = ~clk;

  node_port_arbiter #(.HOLD_TIMEOUT(15), .NODE_IP_BITWIDTH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_instr2(in_instr2),
    .in_ready(in_ready), .link_ready(link_ready),
    .instruction_out(instruction_out), .source_port(source_port),
    .controller_enable(controller_enable), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference arbitration given the model's last winner.
  function automatic int model_grant(input logic [2:0] v);
`ifdef RING_PRIORITY_EN
    int first;
    if (v[1:0] != 2'b00) begin
      first = (m_rr == 0) ? 1 : 0;
      if (v[first]) return first;
      else          return 1 - first;
    end else if (v[2]) begin
      return 2;
    end else begin
      return -1;
    end
`else
    for (int k = 1; k <= 3; k++) begin
      if (v[(m_rr + k) % 3]) return (m_rr + k) % 3;
    end
    return -1;
`endif
  endfunction

  task automatic reset_dut();
    reset    = 1'b1;
    in_valid = 3'b000;
    cyc();
    reset = 1'b0;
    m_rr  = 2;
  endtask

  task automatic check_reset_values();
    chk("rst_instr",   instruction_out, 32'h0000_0000);
    chk("rst_port",    {30'd0, source_port}, 32'd0);
    chk("rst_enable",  {31'd0, controller_enable}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
  endtask

  // Present a request in IDLE, check the grant, log the expected result.
  task automatic accept(input logic [2:0] v);
    int         idx;
    logic [2:0] exp_rdy;
    exp_t       e;
    seq++;
    in_instr0 = 32'h6000_0000 + 32'(seq);
    in_instr1 = 32'h7000_0000 + 32'(seq);
    in_instr2 = 32'h8000_0000 + 32'(seq);
    in_valid  = v;
    #1;
    idx     = model_grant(v);
    exp_rdy = 3'b000;
    if (idx >= 0) begin
      exp_rdy = 3'b001 << idx;
      e.port  = 2'(idx);
      e.instr = (idx == 0) ? in_instr0 : (idx == 1) ? in_instr1 : in_instr2;
      sb.push_back(e);
`ifdef RING_PRIORITY_EN
      if (idx < 2) m_rr = idx;
`else
      m_rr = idx;
`endif
    end
    chk("in_ready", {29'd0, in_ready}, {29'd0, exp_rdy});
    cyc();
  endtask

  // ISSUE cycle: strobe plus scoreboard compare; then first HOLD cycle.
  task automatic issue_check();
    chk("issue_enable", {31'd0, controller_enable}, 32'd1);
    chk("issue_ready",  {29'd0, in_ready}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      last_exp = sb.pop_front();
      chk("issue_instr", instruction_out, last_exp.instr);
      chk("issue_port",  {30'd0, source_port}, {30'd0, last_exp.port});
    end
    chk("issue_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("hold_enable", {31'd0, controller_enable}, 32'd0);
    chk("hold_busy",   {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_hold();
    link_ready = 1'b1;
    cyc();
    chk("done_busy",    {31'd0, busy}, 32'd0);
    chk("done_timeout", {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 3'b000;
    in_instr0  = 32'h0;
    in_instr1  = 32'h0;
    in_instr2  = 32'h0;
    link_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check_reset_values();
    chk("rst_ready", {29'd0, in_ready}, 32'd0);

    // Single right-ring request.
    accept(3'b001);
    in_valid = 3'b000;
    issue_check();
    finish_hold();

    // All sources requesting continuously, link always ready.
    reset_dut();
    link_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      accept(3'b111);
      issue_check();
      finish_hold();
    end
    in_valid = 3'b000;

    // HOLD timeout: 15 cycles waiting, then a one-cycle error pulse.
    link_ready = 1'b0;
    accept(3'b010);
    in_valid = 3'b000;
    issue_check();
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_err",   {31'd0, timeout_err}, 32'd0);
      chk("to_wait_busy",  {31'd0, busy}, 32'd1);
      chk("to_wait_instr", instruction_out, last_exp.instr);
      cyc();
    end
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_idle",  {31'd0, busy}, 32'd0);
    cyc();
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    accept(3'b100);
    in_valid = 3'b000;
    issue_check();
    finish_hold();

    // link_ready arrives on the 6th HOLD cycle: no timeout.
    link_ready = 1'b0;
    accept(3'b001);
    in_valid = 3'b000;
    issue_check();
    for (int k = 0; k < 5; k++) begin
      chk("late_err",   {31'd0, timeout_err}, 32'd0);
      chk("late_instr", instruction_out, last_exp.instr);
      cyc();
    end
    chk("late_busy6", {31'd0, busy}, 32'd1);
    finish_hold();

    // Reset in the middle of HOLD discards the instruction.
    link_ready = 1'b0;
    accept(3'b010);
    in_valid = 3'b000;
    issue_check();
    cyc();
    reset_dut();
    check_reset_values();
    accept(3'b111);
    issue_check();
    finish_hold();

    // Four grants with all valid, then local only.
    for (int i = 0; i < 4; i++) begin
      accept(3'b111);
      issue_check();
      finish_hold();
    end
    accept(3'b100);
    in_valid = 3'b000;
    issue_check();
    finish_hold();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_port_arbiter.md
Name: node_port_arbiter

Overview:
Shares the per-node routing controller between the three traffic sources of a ring node: right-ring input, left-ring input and local injection. Arbitrates round-robin, latches the winning 32-bit instruction with its 2-bit source port code, and pulses controller_enable for exactly one cycle. Holds the instruction stable until the downstream link signals consumption, or until a timeout expires.

Parameters:
HOLD_TIMEOUT, 15, max cycles spent in HOLD waiting for link_ready; 0 disables the timeout
NODE_IP_BITWIDTH, 3, node-ID field width in the instruction; pass-through only, no logic depends on it

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
in_valid  input  3  per-source request: bit0 = right ring (code 2'b00), bit1 = left ring (2'b01), bit2 = local (2'b10)
in_instr0  input  32  right-ring instruction
in_instr1  input  32  left-ring instruction
in_instr2  input  32  local instruction
in_ready  output  3  per-source accept; one-hot or zero
link_ready  input  1  downstream has consumed the current instruction
instruction_out  output  32  latched winning instruction
source_port  output  2  latched port code of the winner
controller_enable  output  1  one-cycle strobe to the routing controller
busy  output  1  high whenever state != IDLE
timeout_err  output  1  one-cycle pulse on HOLD timeout

Behaviour:
- Reset values: state=IDLE, instruction_out=0, source_port=2'b00, controller_enable=0, busy=0, timeout_err=0, rr_last=2'b10 (so bit0 has top priority first), hold counter=0.
- Reset wins over every other event, including a reset asserted mid-HOLD; the in-flight instruction is discarded.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - in_ready is combinational: only the round-robin winner among asserted in_valid bits is high.
  - Transfer occurs on in_valid[i] & in_ready[i].
  - On transfer: latch instruction_out and source_port, set rr_last=i, go to ISSUE.
  - No valid: stay in IDLE with outputs held.
- Round-robin: search starts at rr_last+1 and wraps 2->0. Example: with rr_last=1, the order is 2, 0, 1.
- ISSUE:
  - controller_enable=1 for this cycle only; in_ready=0.
  - Next state is always HOLD; clear the hold counter.
- HOLD:
  - in_ready=0; instruction_out and source_port stay stable.
  - If link_ready=1: go to IDLE.
  - Otherwise increment the counter. When counter==HOLD_TIMEOUT-1 (HOLD_TIMEOUT>0) and link_ready=0: pulse timeout_err next cycle and go to IDLE. The instruction is dropped.
  - link_ready takes precedence over timeout in the same cycle.
  - Counter width is clog2(HOLD_TIMEOUT+1), minimum 1, and it saturates.
- link_ready outside HOLD is ignored.
- Latency: valid accepted in cycle N; controller_enable in N+1; earliest return to IDLE at end of N+2; next acceptance in N+3. Minimum 3 cycles per instruction.
- Requesters must hold in_valid and in_instr stable until accepted. A dropped in_valid before acceptance is legal and is not an error.

Optional Feature:
RING_PRIORITY_EN
- Defined: ring sources (bit0, bit1) round-robin between themselves only. Local bit2 is granted only when in_valid[1:0]==0, so in-flight ring traffic is never blocked by injection. rr_last updates only on ring grants.
- Undefined: plain 3-way round-robin as above.

Test Plan:
- Reset, then in_valid=3'b001, in_instr0=32'h6000_0001 -> in_ready=3'b001 same cycle; next cycle controller_enable=1, source_port=00, instruction_out=32'h6000_0001.
- All three valid continuously, link_ready=1 in every HOLD -> grants in order 0,1,2,0,1,2, one grant every 3 cycles.
- One instruction accepted, link_ready held 0, HOLD_TIMEOUT=15 -> timeout_err pulses exactly once, 15 HOLD cycles after entering HOLD; FSM back in IDLE; next request accepted.
- link_ready held 0 for 5 HOLD cycles, then 1 on the 6th -> no timeout_err; instruction_out unchanged throughout; IDLE next cycle.
- reset asserted during HOLD -> next cycle all outputs at reset values; rr_last=2, so a simultaneous valid=3'b111 grants bit0.
- RING_PRIORITY_EN defined, in_valid=3'b111 for 4 grants -> only 0,1,0,1 granted; drop bits 1:0 -> local granted with source_port=2'b10.
